// File: rtl/ext_ram_wb_fetch.sv
// Wishbone classic read engine for the external-RAM tap, with a one-word
// read buffer and a bounded bus wait so every accepted request completes.
module ext_ram_wb_fetch #(
    parameter int unsigned TIMEOUT  = 1023,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk_sys_i,
    input  logic        rst_n_i,
    input  logic [31:0] ext_ram_adr_i,
    input  logic        ext_ram_rd_i,
    output logic        ext_ram_busy_o,
    output logic [31:0] ext_ram_dat_r_o,
    output logic        ext_ram_valid_o,
    input  logic        cache_inv_i,
    output logic        err_o,
    output logic [29:0] wb_adr_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUS  = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [29:0]   buf_adr;
    logic [31:0]   buf_dat;
    logic          buf_vld;

    logic [29:0] req_adr;
    logic        req_hit;
    logic        req_miss;
    logic        term_err;
    logic        term_ack;
    logic        term_to;
    logic        term_any;
    logic        adr_unused;

    assign req_adr    = ext_ram_adr_i[31:2];
    assign adr_unused = ^ext_ram_adr_i[1:0];

    always_comb begin
        req_hit  = 1'b0;
        req_miss = 1'b0;
        term_err = 1'b0;
        term_ack = 1'b0;
        term_to  = 1'b0;
        if (state == S_IDLE && ext_ram_rd_i) begin
            req_hit  = buf_vld && (buf_adr == req_adr);
            req_miss = !req_hit;
        end
        // Error outranks ack, and both outrank the wait limit.
        if (state == S_BUS) begin
            term_err = wb_err_i;
            term_ack = !wb_err_i && wb_ack_i;
            term_to  = !wb_err_i && !wb_ack_i && (cnt == CNT_MAX);
        end
        term_any = term_err || term_ack || term_to;
    end

    assign ext_ram_busy_o = (state == S_BUS);
    assign wb_cyc_o       = ext_ram_busy_o;
    assign wb_stb_o       = ext_ram_busy_o;
    assign wb_we_o        = 1'b0;
    assign wb_sel_o       = 4'hF;

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state           <= S_IDLE;
            cnt             <= '0;
            wb_adr_o        <= '0;
            ext_ram_dat_r_o <= '0;
            ext_ram_valid_o <= 1'b0;
            err_o           <= 1'b0;
        end else begin
            ext_ram_valid_o <= 1'b0;
            err_o           <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_hit) begin
                        ext_ram_dat_r_o <= buf_dat;
                        ext_ram_valid_o <= 1'b1;
                    end else if (req_miss) begin
                        wb_adr_o <= req_adr;
                        cnt      <= '0;
                        state    <= S_BUS;
                    end
                end
                S_BUS: begin
                    if (term_any) begin
                        state           <= S_IDLE;
                        ext_ram_valid_o <= 1'b1;
                        ext_ram_dat_r_o <= term_ack ? wb_dat_i : ERR_DATA;
                        err_o           <= !term_ack;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Invalidate beats a same-cycle fill; the fill data still goes out.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            buf_adr <= '0;
            buf_dat <= '0;
            buf_vld <= 1'b0;
        end else begin
            if (term_ack) begin
                buf_adr <= wb_adr_o;
                buf_dat <= wb_dat_i;
                buf_vld <= 1'b1;
            end
            if (cache_inv_i) begin
                buf_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ext_ram_wb_fetch.sv
// Directed and randomized read traffic against a transaction-level model
// of the one-word buffer and the bus termination rules.
module tb_ext_ram_wb_fetch;

    localparam int unsigned TO = 8;
    localparam logic [31:0] ED = 32'hDEADBEEF;
    localparam int R_ACK  = 0;
    localparam int R_ERR  = 1;
    localparam int R_BOTH = 2;
    localparam int R_NONE = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] adr;
    logic        rd;
    logic        busy;
    logic [31:0] dat;
    logic        valid;
    logic        inv;
    logic        err_o;
    logic [29:0] wb_adr;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wb_dat;
    logic        ack;
    logic        err_in;

    int errors = 0;
    int checks = 0;

    bit          m_vld;
    logic [29:0] m_adr;
    logic [31:0] m_dat;
    logic [31:0] last_dat;

    ext_ram_wb_fetch #(.TIMEOUT(TO), .ERR_DATA(ED)) dut (
        .clk_sys_i      (clk),
        .rst_n_i        (rst_n),
        .ext_ram_adr_i  (adr),
        .ext_ram_rd_i   (rd),
        .ext_ram_busy_o (busy),
        .ext_ram_dat_r_o(dat),
        .ext_ram_valid_o(valid),
        .cache_inv_i    (inv),
        .err_o          (err_o),
        .wb_adr_o       (wb_adr),
        .wb_cyc_o       (cyc),
        .wb_stb_o       (stb),
        .wb_we_o        (we),
        .wb_sel_o       (sel),
        .wb_dat_i       (wb_dat),
        .wb_ack_i       (ack),
        .wb_err_i       (err_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_valid", valid, 0);
            chk("idle_err", err_o, 0);
            chk("idle_busy", busy, 0);
            chk("idle_cyc", cyc, 0);
            chk("idle_dat_hold", dat, last_dat);
        end
    endtask

    // Called at a negedge; request is sampled on the following posedge.
    task automatic do_read(input logic [31:0] a, input int mode,
                           input int dly, input logic [31:0] sdat,
                           input bit inv_req, input bit inv_term,
                           input bit noise);
        bit hit;
        bit fill;
        int term_i;
        logic [31:0] exp_d;
        hit = m_vld && (m_adr == a[31:2]);
        rd  = 1'b1;
        adr = a;
        inv = inv_req;
        @(negedge clk);
        rd  = 1'b0;
        inv = 1'b0;
        if (hit) begin
            chk("hit_valid", valid, 1);
            chk("hit_dat", dat, m_dat);
            chk("hit_busy", busy, 0);
            chk("hit_cyc", cyc, 0);
            last_dat = m_dat;
            if (inv_req) m_vld = 1'b0;
            return;
        end
        if (inv_req) m_vld = 1'b0;
        chk("miss_busy", busy, 1);
        chk("miss_cyc", cyc, 1);
        chk("miss_stb", stb, 1);
        chk("miss_wb_adr", wb_adr, a[31:2]);
        chk("miss_valid", valid, 0);
        term_i = (mode == R_NONE || dly > int'(TO) + 1) ? int'(TO) + 1 : dly;
        fill   = (mode == R_ACK) && (dly <= int'(TO) + 1);
        exp_d  = fill ? sdat : ED;
        for (int i = 1; i <= int'(TO) + 2; i++) begin
            ack    = (i == dly) && (mode == R_ACK || mode == R_BOTH);
            err_in = (i == dly) && (mode == R_ERR || mode == R_BOTH);
            wb_dat = (i == dly) ? sdat : $urandom;
            inv    = inv_term && (i == term_i);
            rd     = noise && ($urandom_range(0, 1) == 1);
            adr    = noise ? $urandom : a;
            @(negedge clk);
            ack    = 1'b0;
            err_in = 1'b0;
            inv    = 1'b0;
            rd     = 1'b0;
            if (i == term_i) begin
                chk("done_valid", valid, 1);
                chk("done_dat", dat, exp_d);
                chk("done_err", err_o, fill ? 0 : 1);
                chk("done_busy", busy, 0);
                chk("done_cyc", cyc, 0);
                if (fill) begin
                    m_adr = a[31:2];
                    m_dat = sdat;
                    m_vld = !inv_term;
                end else if (inv_term) begin
                    m_vld = 1'b0;
                end
                last_dat = exp_d;
                break;
            end
            chk("bus_valid", valid, 0);
            chk("bus_busy", busy, 1);
            chk("bus_dat_hold", dat, last_dat);
        end
    endtask

    initial begin
        logic [31:0] pool [4];
        logic [31:0] a;
        int mode;
        rst_n  = 1'b0;
        adr    = '0;
        rd     = 1'b0;
        inv    = 1'b0;
        wb_dat = '0;
        ack    = 1'b0;
        err_in = 1'b0;
        m_vld  = 1'b0;
        m_adr  = '0;
        m_dat  = '0;
        last_dat = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", valid, 0);
        chk("rst_err", err_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cyc", cyc, 0);
        chk("rst_stb", stb, 0);
        chk("rst_dat", dat, 0);
        chk("rst_wb_adr", wb_adr, 0);
        chk("rst_sel", sel, 4'hF);
        chk("rst_we", we, 0);
        rst_n = 1'b1;
        idle(100);

        do_read(32'h0000_1004, R_ACK, 3, 32'hCAFE0001, 0, 0, 0);
        idle(1);
        do_read(32'h0000_1006, R_ACK, 1, 32'h0, 0, 0, 0);
        do_read(32'h0000_1004, R_ACK, 1, 32'h0, 0, 0, 0);
        inv = 1'b1;
        @(negedge clk);
        inv = 1'b0;
        m_vld = 1'b0;
        do_read(32'h0000_1004, R_ACK, 1, 32'h1234_5678, 0, 0, 0);
        do_read(32'h0000_2000, R_ACK, 2, 32'hA5A5_0002, 0, 1, 0);
        do_read(32'h0000_2000, R_ACK, 1, 32'hA5A5_0003, 0, 0, 0);
        do_read(32'h0000_2000, R_ACK, 1, 32'h0, 1, 0, 0);
        do_read(32'h0000_2000, R_ACK, 2, 32'hA5A5_0004, 0, 0, 0);

        do_read(32'h0000_3000, R_NONE, 0, 32'h0, 0, 0, 0);
        do_read(32'h0000_3000, R_ACK, 2, 32'h3333_0001, 0, 0, 0);
        do_read(32'h0000_4000, R_BOTH, 2, 32'h4444_0001, 0, 0, 1);
        idle(1);
        do_read(32'h0000_4000, R_ERR, 3, 32'h4444_0002, 0, 0, 1);
        do_read(32'h0000_4000, R_ACK, 1, 32'h4444_0003, 0, 0, 0);
        do_read(32'h0000_4000, R_ACK, 1, 32'h0, 0, 0, 0);

        rd  = 1'b1;
        adr = 32'h0000_5000;
        @(negedge clk);
        rd = 1'b0;
        chk("mid_cyc_up", cyc, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cyc", cyc, 0);
        chk("mid_rst_stb", stb, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_dat", dat, 0);
        chk("mid_rst_wb_adr", wb_adr, 0);
        m_vld = 1'b0;
        last_dat = '0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        do_read(32'h0000_4000, R_ACK, 1, 32'h4444_0005, 0, 0, 0);
        do_read(32'h0000_5000, R_ACK, 2, 32'h5555_0001, 0, 0, 0);

        pool[0] = 32'h0000_1000;
        pool[1] = 32'h0000_1004;
        pool[2] = 32'h0000_2008;
        pool[3] = 32'h0000_300C;
        for (int k = 0; k < 80; k++) begin
            a = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
            mode = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                              : R_ACK;
            do_read(a, mode, int'($urandom_range(1, TO + 3)), $urandom,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 1) == 1);
            idle(int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
